// File: rtl/time_setter_if.sv
// Button, current-time and load/status bundle between the time setter and its surroundings.
// The slave modport is the setter's view; master is the driving side (counter/buttons).
interface time_setter_if;
  logic       seconds_pulse_i;
  logic       btn_mode_i;
  logic       btn_up_i;
  logic       btn_down_i;
  logic       btn_cancel_i;
  logic [4:0] cur_hours_i;
  logic [5:0] cur_minutes_i;
  logic [6:0] cur_seconds_i;
  logic [4:0] load_hours_o;
  logic [5:0] load_minutes_o;
  logic [6:0] load_seconds_o;
  logic       load_time_o;
  logic       count_enable_o;
  logic [1:0] edit_field_o;

  modport master (
    output seconds_pulse_i, btn_mode_i, btn_up_i, btn_down_i, btn_cancel_i,
    output cur_hours_i, cur_minutes_i, cur_seconds_i,
    input  load_hours_o, load_minutes_o, load_seconds_o,
    input  load_time_o, count_enable_o, edit_field_o
  );

  modport slave (
    input  seconds_pulse_i, btn_mode_i, btn_up_i, btn_down_i, btn_cancel_i,
    input  cur_hours_i, cur_minutes_i, cur_seconds_i,
    output load_hours_o, load_minutes_o, load_seconds_o,
    output load_time_o, count_enable_o, edit_field_o
  );
endinterface

// File: rtl/time_setter.sv
// Clock time-setting FSM: capture, edit H/M/S with wrap, commit via one-cycle load strobe.
// One-edge latency, outputs decoded from registers only; no backpressure (pulses always accepted).
module time_setter #(
  parameter int TIMEOUT_SEC = 10
) (
  input logic        clk_100MHz_i,
  input logic        reset_n_i,
  time_setter_if.slave ts
);

  localparam int CNT_W = $clog2(TIMEOUT_SEC + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_SEC);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EDIT_H = 3'd1,
    EDIT_M = 3'd2,
    EDIT_S = 3'd3,
    COMMIT = 3'd4
  } state_t;

  state_t           state_q, state_nxt;
  logic [4:0]       hours_q, hours_nxt;
  logic [5:0]       minutes_q, minutes_nxt;
  logic [6:0]       seconds_q, seconds_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  logic any_btn;
  logic step_up;
  logic step_dn;

  function automatic logic [6:0] step_field(input logic [6:0] v, input logic [6:0] max_v,
                                            input logic up);
    if (up) return (v == max_v) ? 7'd0 : v + 7'd1;
    else    return (v == 7'd0) ? max_v : v - 7'd1;
  endfunction

  assign any_btn = ts.btn_mode_i | ts.btn_up_i | ts.btn_down_i | ts.btn_cancel_i;
  // Opposing pulses in one cycle cancel out.
  assign step_up = ts.btn_up_i & ~ts.btn_down_i;
  assign step_dn = ts.btn_down_i & ~ts.btn_up_i;

  always_comb begin
    state_nxt   = state_q;
    hours_nxt   = hours_q;
    minutes_nxt = minutes_q;
    seconds_nxt = seconds_q;
    cnt_nxt     = cnt_q;

    case (state_q)
      IDLE: begin
        cnt_nxt = '0;
        if (ts.btn_mode_i) begin
          hours_nxt   = (ts.cur_hours_i   > 5'd23) ? 5'd0 : ts.cur_hours_i;
          minutes_nxt = (ts.cur_minutes_i > 6'd59) ? 6'd0 : ts.cur_minutes_i;
          seconds_nxt = (ts.cur_seconds_i > 7'd59) ? 7'd0 : ts.cur_seconds_i;
          state_nxt   = EDIT_H;
        end
      end

      EDIT_H, EDIT_M, EDIT_S: begin
        if (any_btn) begin
          cnt_nxt = '0;
        end else if (ts.seconds_pulse_i && cnt_q != TO_VAL) begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end

        if (ts.btn_cancel_i) begin
          state_nxt = IDLE;
        end else if (ts.btn_mode_i) begin
          case (state_q)
            EDIT_H:  state_nxt = EDIT_M;
            EDIT_M:  state_nxt = EDIT_S;
            default: state_nxt = COMMIT;
          endcase
        end else if (step_up || step_dn) begin
          case (state_q)
            EDIT_H:  hours_nxt   = 5'(step_field({2'b00, hours_q}, 7'd23, step_up));
            EDIT_M:  minutes_nxt = 6'(step_field({1'b0, minutes_q}, 7'd59, step_up));
            default: seconds_nxt = step_field(seconds_q, 7'd59, step_up);
          endcase
        end else if (!any_btn && cnt_q == TO_VAL) begin
          // Expired inactivity window: leave edit without committing.
          state_nxt = IDLE;
        end

        if (state_nxt == IDLE || state_nxt == COMMIT) cnt_nxt = '0;
      end

      COMMIT: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_nxt;
      hours_q   <= hours_nxt;
      minutes_q <= minutes_nxt;
      seconds_q <= seconds_nxt;
      cnt_q     <= cnt_nxt;
    end
  end

  assign ts.load_hours_o   = hours_q;
  assign ts.load_minutes_o = minutes_q;
  assign ts.load_seconds_o = seconds_q;
  assign ts.load_time_o    = (state_q == COMMIT);
  assign ts.count_enable_o = (state_q == IDLE);

  always_comb begin
    ts.edit_field_o = 2'b00;
    case (state_q)
      EDIT_H:  ts.edit_field_o = 2'b01;
      EDIT_M:  ts.edit_field_o = 2'b10;
      EDIT_S:  ts.edit_field_o = 2'b11;
      default: ts.edit_field_o = 2'b00;
    endcase
  end

endmodule

// File: doc/time_setter.md
TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 The block SHALL have one parameter, TIMEOUT_SEC, default 10: the number of seconds_pulse_i ticks with no button pulse, after which edit mode is abandoned.
REQ-002 clk_100MHz_i  in  1  the single clock; all logic is rising-edge.
REQ-003 reset_n_i  in  1  asynchronous, active-low reset.
REQ-004 seconds_pulse_i  in  1  one-cycle tick at 1 Hz.
REQ-005 btn_mode_i, btn_up_i, btn_down_i, btn_cancel_i  in  1 each  single-cycle pulses, already debounced.
REQ-006 cur_hours_i  in  5, cur_minutes_i  in  6, cur_seconds_i  in  7  current time from the time counter.
REQ-007 load_hours_o  out  5, load_minutes_o  out  6, load_seconds_o  out  7  time value to load into the counter.
REQ-008 load_time_o  out  1  one-cycle load strobe to the counter.
REQ-009 count_enable_o  out  1  counter run enable.
REQ-010 edit_field_o  out  2  field being edited: 00 none, 01 hours, 10 minutes, 11 seconds.

Function
REQ-011 The block SHALL use a state machine with states IDLE, EDIT_H, EDIT_M, EDIT_S and COMMIT, with all state held in registers.
REQ-012 On btn_mode_i in IDLE, the block SHALL capture cur_* into the edit registers and enter EDIT_H on the next edge.
REQ-013 On capture, any field out of range SHALL be replaced by 0: hours above 23, minutes above 59, seconds above 59.
REQ-014 btn_mode_i SHALL advance the state EDIT_H -> EDIT_M -> EDIT_S -> COMMIT.
REQ-015 COMMIT SHALL last exactly one cycle and then return to IDLE.
REQ-016 load_time_o SHALL be 1 only while the state is COMMIT.
REQ-017 load_* outputs SHALL drive the edit registers continuously in every state.
REQ-018 In the active EDIT state, btn_up_i SHALL increment the selected field and btn_down_i SHALL decrement it, each by 1 per pulse.
REQ-019 Increment and decrement SHALL wrap: hours 23<->0, minutes 59<->0, seconds 59<->0.
REQ-020 Fields that are not selected SHALL hold their value.
REQ-021 If btn_up_i and btn_down_i arrive in the same cycle, the block SHALL change no field.
REQ-022 Button priority SHALL be cancel > mode > up/down.
REQ-023 If btn_mode_i arrives together with up or down, the block SHALL advance the state and leave the fields unchanged.
REQ-024 btn_cancel_i in any EDIT state SHALL return the block to IDLE with no load strobe.
REQ-025 btn_cancel_i, btn_up_i and btn_down_i SHALL have no effect in IDLE or COMMIT.
REQ-026 btn_mode_i SHALL have no effect in COMMIT.
REQ-027 An inactivity counter SHALL clear to 0 on any button pulse and on entry to EDIT_H.
REQ-028 In EDIT states, the inactivity counter SHALL increment on each seconds_pulse_i that has no same-cycle button pulse.
REQ-029 When the inactivity counter reaches TIMEOUT_SEC, the block SHALL enter IDLE on the next edge with no load strobe.
REQ-030 The inactivity counter SHALL be at least clog2(TIMEOUT_SEC+1) bits wide.
REQ-031 count_enable_o SHALL be 1 in IDLE and 0 in EDIT_* and COMMIT.
REQ-032 edit_field_o SHALL follow the state: 01 in EDIT_H, 10 in EDIT_M, 11 in EDIT_S, 00 in IDLE and COMMIT.
REQ-033 Latency SHALL be one edge: a button in cycle n gives the new state and outputs in cycle n+1.
REQ-034 All outputs SHALL be decoded from registers only, with no combinational path from any input to any output.

Reset
REQ-035 Asserting reset_n_i low SHALL immediately force state IDLE, all edit registers 0 and the inactivity counter 0.
REQ-036 During reset, outputs SHALL be load_time_o 0, count_enable_o 1, edit_field_o 00 and load_* 0.
REQ-037 Reset asserted mid-edit or during COMMIT SHALL abort the edit, with no load strobe after release.
REQ-038 After reset_n_i releases, the first state change SHALL occur on a clock edge.

Verification
REQ-039 Full edit: cur=13:45:30, then mode, up x2, mode, down, mode, mode -> exactly one load_time_o pulse with load=15:44:30, then IDLE with count_enable_o 1.
REQ-040 Wrap: edit hours=23 with up -> 0; edit minutes=0 with down -> 59; edit seconds=59 with up -> 0.
REQ-041 Cancel: cancel in EDIT_M after two ups -> IDLE, load_time_o never 1, count_enable_o 1 on the next cycle.
REQ-042 Timeout: TIMEOUT_SEC=3, enter EDIT_H, send 3 seconds_pulse_i with no buttons -> IDLE after the third, no strobe; a button between pulses restarts the count.
REQ-043 Simultaneous buttons: up+down in the same cycle -> fields unchanged; mode+up in EDIT_H -> EDIT_M, hours unchanged; cancel+mode -> IDLE.
REQ-044 Async reset: assert reset_n_i between clock edges during EDIT_S -> outputs go to reset values before the next edge, with no load pulse after release.
